// File: rtl/pqr5_core_pkg.sv
// Shared PQR5 core definitions: ALU opcode encoding and register-file address width.
package pqr5_core_pkg;

  localparam int RF_AW = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

endpackage

// File: rtl/regfile.sv
// Integer register file: two asynchronous read ports, one synchronous write port.
// Entry 0 is never written and always reads as zero; storage is not reset.
module regfile
  import pqr5_core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic [RF_AW-1:0] ra0_i,
  input  logic [RF_AW-1:0] ra1_i,
  output logic [XLEN-1:0]  rd0_o,
  output logic [XLEN-1:0]  rd1_o,
  input  logic             we_i,
  input  logic [RF_AW-1:0] wa_i,
  input  logic [XLEN-1:0]  wd_i
);

  logic [XLEN-1:0] mem_q [NREGS];

  always_ff @(posedge clk) begin
    if (we_i && (wa_i != '0)) begin
      mem_q[wa_i] <= wd_i;
    end
  end

  assign rd0_o = (ra0_i == '0) ? '0 : mem_q[ra0_i];
  assign rd1_o = (ra1_i == '0) ? '0 : mem_q[ra1_i];

endmodule

// File: rtl/opfu_stage.sv
// Operand-fetch stage: RF read, EXU/WB forwarding, load-use bubble insertion, and the
// registered operand/opcode/destination bundle toward the ALU (1-cycle latency).
module opfu_stage
  import pqr5_core_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             i_stall,
  input  logic             i_bubble,
  input  logic [4:0]       i_rs0,
  input  logic [4:0]       i_rs1,
  input  logic             i_rs0_use,
  input  logic             i_rs1_use,
  input  logic [XLEN-1:0]  i_imm,
  input  logic             i_use_imm,
  input  logic [3:0]       i_alu_opcode,
  input  logic [4:0]       i_rdt,
  input  logic             i_rdt_wr,
  input  logic             i_is_load,
  input  logic [4:0]       i_exu_rdt,
  input  logic             i_exu_rdt_wr,
  input  logic             i_exu_is_load,
  input  logic [XLEN-1:0]  i_exu_result,
  input  logic             i_wb_en,
  input  logic [4:0]       i_wb_rdt,
  input  logic [XLEN-1:0]  i_wb_data,
  output logic [XLEN-1:0]  o_op0,
  output logic [XLEN-1:0]  o_op1,
  output logic [3:0]       o_alu_opcode,
  output logic [4:0]       o_rdt,
  output logic             o_rdt_wr,
  output logic             o_is_load,
  output logic             o_bubble,
  output logic             o_stall
);

  logic [XLEN-1:0] rf_rd0, rf_rd1;
  logic [XLEN-1:0] rs0_val, rs1_val;
  logic [XLEN-1:0] op0_d, op1_d, op0_q, op1_q;
  logic [3:0]      opcode_q;
  logic [4:0]      rdt_q;
  logic            rdt_wr_q, is_load_q, bubble_q;
  logic            bubble_d, hzd;

  regfile #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
    .clk   (clk),
    .ra0_i (i_rs0),
    .ra1_i (i_rs1),
    .rd0_o (rf_rd0),
    .rd1_o (rf_rd1),
    .we_i  (i_wb_en),
    .wa_i  (i_wb_rdt),
    .wd_i  (i_wb_data)
  );

  // EXU wins over WB: it holds the younger value. A load in EXU has no data yet.
  function automatic logic [XLEN-1:0] resolve(input logic [4:0] rs, input logic [XLEN-1:0] rf_val);
    if (rs == '0)                                                  return '0;
    else if (i_exu_rdt_wr && !i_exu_is_load && (i_exu_rdt == rs)) return i_exu_result;
    else if (i_wb_en && (i_wb_rdt == rs))                          return i_wb_data;
    else                                                           return rf_val;
  endfunction

  always_comb begin
    rs0_val = resolve(i_rs0, rf_rd0);
    rs1_val = resolve(i_rs1, rf_rd1);
  end

  assign op0_d = rs0_val;
  assign op1_d = i_use_imm ? i_imm : rs1_val;

  assign hzd = !i_bubble && i_exu_rdt_wr && i_exu_is_load && (i_exu_rdt != '0) &&
               ((i_rs0_use && (i_rs0 == i_exu_rdt)) ||
                (i_rs1_use && (i_rs1 == i_exu_rdt) && !i_use_imm));

  assign bubble_d = i_bubble || hzd;
  assign o_stall  = aresetn && (hzd || i_stall);

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      op0_q     <= '0;
      op1_q     <= '0;
      opcode_q  <= ALU_ADD;
      rdt_q     <= '0;
      rdt_wr_q  <= 1'b0;
      is_load_q <= 1'b0;
      bubble_q  <= 1'b1;
    end else if (!i_stall) begin
      op0_q     <= op0_d;
      op1_q     <= op1_d;
      opcode_q  <= i_alu_opcode;
      rdt_q     <= i_rdt;
      rdt_wr_q  <= i_rdt_wr && !bubble_d;
      is_load_q <= i_is_load && !bubble_d;
      bubble_q  <= bubble_d;
    end
  end

  assign o_op0        = op0_q;
  assign o_op1        = op1_q;
  assign o_alu_opcode = opcode_q;
  assign o_rdt        = rdt_q;
  assign o_rdt_wr     = rdt_wr_q;
  assign o_is_load    = is_load_q;
  assign o_bubble     = bubble_q;

endmodule
